// File: rtl/input_mapper_if.sv
// Player-input bus between the hps_io side (master) and input_mapper (slave).
// Carries PS/2 events, joysticks, keymap writes and the merged, registered controls.
interface input_mapper_if #(
  parameter int PLAYERS = 2,
  parameter int JOY_W   = 10,
  parameter int SERVICE = 2
);
  localparam int N  = PLAYERS * JOY_W + SERVICE;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [10:0]              ps2_key;
  logic [PLAYERS*JOY_W-1:0] joystick;
  logic                     map_wr;
  logic [AW-1:0]            map_addr;
  logic [9:0]               map_data;
  logic                     key_clear;
  logic [PLAYERS*JOY_W-1:0] autofire_en;
  logic [PLAYERS*JOY_W-1:0] ctrl_out;
  logic [SERVICE-1:0]       service_out;

  modport master (
    output ps2_key, joystick, map_wr, map_addr, map_data, key_clear, autofire_en,
    input  ctrl_out, service_out
  );

  modport slave (
    input  ps2_key, joystick, map_wr, map_addr, map_data, key_clear, autofire_en,
    output ctrl_out, service_out
  );
endinterface

// File: rtl/input_mapper.sv
// Table-driven PS/2 keymap merged with joysticks, plus per-bit autofire and coin stretch.
// Registered outputs: 1 cycle from joystick/autofire phase, 2 edges from a PS/2 event; no backpressure.
module input_mapper #(
  parameter int          PLAYERS   = 2,
  parameter int          JOY_W     = 10,
  parameter int          SERVICE   = 2,
  parameter int          COIN_BIT  = 8,
  parameter logic [15:0] COIN_HOLD = 16'd50000,
  parameter logic [23:0] AF_DIV    = 24'd400000
) (
  input  logic           clk_sys,
  input  logic           RESET,
  input_mapper_if.slave  io
);
  localparam int PW = PLAYERS * JOY_W;
  localparam int N  = PW + SERVICE;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  map_valid;
  logic [N-1:0]  map_ext;
  logic [7:0]    map_code [N];
  logic          old_tog;
  logic          primed;
  logic          ps2_evt;
  logic          wr_ok;
  logic [N-1:0]  key_state;
  logic [N-1:0]  key_next;
  logic [23:0]   af_cnt;
  logic          af_phase;
  logic [15:0]   cc [PLAYERS];
  logic [PLAYERS-1:0] coin_prev;
  logic [PW-1:0] raw;
  logic [PW-1:0] ctrl_next;

  // The first edge after reset only captures the toggle, so a stale level never decodes.
  assign ps2_evt = primed & (io.ps2_key[10] != old_tog);
  assign wr_ok   = io.map_wr & ({1'b0, io.map_addr} < (AW+1)'(N));

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      map_valid <= '0;
      map_ext   <= '0;
      for (int i = 0; i < N; i++) map_code[i] <= '0;
    end else if (wr_ok) begin
      map_valid[io.map_addr] <= io.map_data[9];
      map_ext[io.map_addr]   <= io.map_data[8];
      map_code[io.map_addr]  <= io.map_data[7:0];
    end
  end

  // Decode uses the pre-write table; clear and entry rewrite override the decoded level.
  always_comb begin
    key_next = key_state;
    if (ps2_evt) begin
      for (int i = 0; i < N; i++) begin
        if (map_valid[i] && (map_ext[i] == io.ps2_key[8]) && (map_code[i] == io.ps2_key[7:0]))
          key_next[i] = io.ps2_key[9];
      end
    end
    if (io.key_clear) key_next = '0;
    if (wr_ok) key_next[io.map_addr] = 1'b0;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      old_tog   <= 1'b0;
      primed    <= 1'b0;
      key_state <= '0;
    end else begin
      old_tog   <= io.ps2_key[10];
      primed    <= 1'b1;
      key_state <= key_next;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_DIV - 24'd1) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt + 24'd1;
    end
  end

  assign raw = key_state[PW-1:0] | io.joystick;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      coin_prev <= '0;
      for (int p = 0; p < PLAYERS; p++) cc[p] <= '0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        coin_prev[p] <= raw[p*JOY_W+COIN_BIT];
        if (raw[p*JOY_W+COIN_BIT] && !coin_prev[p])
          cc[p] <= COIN_HOLD - 16'd1;
        else if (cc[p] != '0)
          cc[p] <= cc[p] - 16'd1;
      end
    end
  end

  always_comb begin
    ctrl_next = raw;
    for (int i = 0; i < PW; i++) begin
      if (io.autofire_en[i] && ((i % JOY_W) != COIN_BIT))
        ctrl_next[i] = raw[i] & ~af_phase;
    end
    for (int p = 0; p < PLAYERS; p++)
      ctrl_next[p*JOY_W+COIN_BIT] = raw[p*JOY_W+COIN_BIT] | (cc[p] != '0);
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      io.ctrl_out    <= '0;
      io.service_out <= '0;
    end else begin
      io.ctrl_out    <= ctrl_next;
      io.service_out <= key_state[N-1:PW];
    end
  end
endmodule

// File: tb/tb_input_mapper.sv
// Scoreboard bench for input_mapper: stimulus pushes timed expectations, a monitor
// pops and compares them one time unit after each rising clock edge.
module tb_input_mapper;
  localparam int PLAYERS = 2;
  localparam int JOY_W   = 10;
  localparam int SERVICE = 2;
  localparam int AF      = 4;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  input_mapper_if #(.PLAYERS(PLAYERS), .JOY_W(JOY_W), .SERVICE(SERVICE)) bus ();

  input_mapper #(
    .PLAYERS(PLAYERS), .JOY_W(JOY_W), .SERVICE(SERVICE), .COIN_BIT(8),
    .COIN_HOLD(16'd8), .AF_DIV(24'd4)
  ) dut (
    .clk_sys(clk_sys),
    .RESET(RESET),
    .io(bus)
  );

  typedef struct {
    string       tag;
    int          due;
    int          kind;   // 0: one ctrl_out bit, 1: whole ctrl_out, 2: whole service_out
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  keep_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rst_cyc  = 0;
  logic tog      = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk_sys) begin
    logic [31:0] obs;
    #1;
    cyc++;
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].due == cyc) begin
        case (sb_q[i].kind)
          0:       obs = {31'b0, bus.ctrl_out[sb_q[i].idx]};
          1:       obs = 32'(bus.ctrl_out);
          default: obs = 32'(bus.service_out);
        endcase
        check_val(sb_q[i].tag, obs, sb_q[i].exp);
      end else begin
        keep_q.push_back(sb_q[i]);
      end
    end
    sb_q = keep_q;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic expect_at(input string tag, input int ofs, input int kind, input int idx,
                           input logic [31:0] e);
    sb_t s;
    s.tag = tag; s.due = cyc + ofs; s.kind = kind; s.idx = idx; s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic ps2(input logic p, input logic e, input logic [7:0] c);
    tog = ~tog;
    bus.ps2_key = {tog, p, e, c};
  endtask

  task automatic map_write(input int a, input logic v, input logic e, input logic [7:0] c);
    bus.map_wr   = 1'b1;
    bus.map_addr = 5'(a);
    bus.map_data = {v, e, c};
    tick(1);
    bus.map_wr   = 1'b0;
  endtask

  // Autofire phase after edge number k: toggles every AF edges counted from reset release.
  function automatic logic phase_after(input int k);
    return 1'(((k - rst_cyc) / AF) % 2);
  endfunction

  initial begin
    bus.ps2_key = '0; bus.joystick = '0; bus.map_wr = 1'b0; bus.map_addr = '0;
    bus.map_data = '0; bus.key_clear = 1'b0; bus.autofire_en = '0;
    tick(2);
    check_val("rst_ctrl", 32'(bus.ctrl_out), 32'h0);
    check_val("rst_svc", 32'(bus.service_out), 32'h0);
    RESET = 1'b0; rst_cyc = cyc;
    tick(2);

    // Basic keymap press/release on entry 4
    map_write(4, 1'b1, 1'b0, 8'h14);
    ps2(1'b1, 1'b0, 8'h14);
    expect_at("key4_lat", 1, 0, 4, 32'h0);
    expect_at("key4_press", 2, 0, 4, 32'h1);
    tick(3);
    ps2(1'b0, 1'b0, 8'h14);
    expect_at("key4_hold", 1, 0, 4, 32'h1);
    expect_at("key4_rel", 2, 0, 4, 32'h0);
    tick(3);

    // Extended flag must match
    map_write(3, 1'b1, 1'b1, 8'h75);
    ps2(1'b1, 1'b0, 8'h75);
    expect_at("ext_nomatch", 2, 1, 0, 32'h0);
    tick(3);
    ps2(1'b1, 1'b1, 8'h75);
    expect_at("ext_match", 2, 1, 0, 32'h8);
    tick(3);
    ps2(1'b0, 1'b1, 8'h75);
    expect_at("ext_rel", 2, 1, 0, 32'h0);
    tick(3);

    // Two entries share one code; service inputs
    map_write(0, 1'b1, 1'b0, 8'h1c);
    map_write(20, 1'b1, 1'b0, 8'h1c);
    map_write(21, 1'b1, 1'b0, 8'h05);
    ps2(1'b1, 1'b0, 8'h1c);
    expect_at("multi_ctrl", 2, 1, 0, 32'h1);
    expect_at("multi_svc", 2, 2, 0, 32'h1);
    tick(3);
    ps2(1'b1, 1'b0, 8'h05);
    expect_at("svc_both", 2, 2, 0, 32'h3);
    tick(3);
    ps2(1'b0, 1'b0, 8'h1c);
    tick(1);
    ps2(1'b0, 1'b0, 8'h05);
    expect_at("svc_rel", 2, 2, 0, 32'h0);
    expect_at("multi_rel", 2, 1, 0, 32'h0);
    tick(3);

    // Out-of-range write is dropped
    map_write(22, 1'b1, 1'b0, 8'h29);
    ps2(1'b1, 1'b0, 8'h29);
    expect_at("oob_ctrl", 2, 1, 0, 32'h0);
    expect_at("oob_svc", 2, 2, 0, 32'h0);
    tick(3);
    ps2(1'b0, 1'b0, 8'h29);
    tick(2);

    // Same-edge rewrite of entry 4 and a matching press: clear wins
    bus.map_wr = 1'b1; bus.map_addr = 5'd4; bus.map_data = {1'b1, 1'b0, 8'h14};
    ps2(1'b1, 1'b0, 8'h14);
    expect_at("wr_evt_clr", 2, 0, 4, 32'h0);
    expect_at("wr_evt_clr2", 3, 0, 4, 32'h0);
    tick(1);
    bus.map_wr = 1'b0;
    tick(3);
    ps2(1'b1, 1'b0, 8'h14);
    expect_at("press_after_wr", 2, 0, 4, 32'h1);
    tick(3);

    // key_clear with the key held, then key_clear against a simultaneous press
    bus.key_clear = 1'b1;
    expect_at("clr_hold", 1, 0, 4, 32'h1);
    expect_at("clr_drop", 2, 0, 4, 32'h0);
    tick(1);
    bus.key_clear = 1'b0;
    tick(3);
    bus.key_clear = 1'b1;
    ps2(1'b1, 1'b1, 8'h75);
    expect_at("clr_prio", 2, 0, 3, 32'h0);
    expect_at("clr_prio2", 3, 0, 3, 32'h0);
    tick(1);
    bus.key_clear = 1'b0;
    tick(3);

    // Joystick passes through in one cycle
    bus.joystick[5] = 1'b1;
    expect_at("joy_on", 1, 0, 5, 32'h1);
    tick(2);
    bus.joystick[5] = 1'b0;
    expect_at("joy_off", 1, 0, 5, 32'h0);
    tick(2);

    // Coin stretch: single pulse, then retrigger at +5
    bus.joystick[8] = 1'b1;
    for (int k = 1; k <= 8; k++) expect_at($sformatf("coin_hi%0d", k), k, 0, 8, 32'h1);
    expect_at("coin_end", 9, 0, 8, 32'h0);
    tick(1);
    bus.joystick[8] = 1'b0;
    tick(10);
    bus.joystick[8] = 1'b1;
    for (int k = 1; k <= 13; k++) expect_at($sformatf("retrig_hi%0d", k), k, 0, 8, 32'h1);
    expect_at("retrig_end", 14, 0, 8, 32'h0);
    tick(1);
    bus.joystick[8] = 1'b0;
    tick(4);
    bus.joystick[8] = 1'b1;
    tick(1);
    bus.joystick[8] = 1'b0;
    tick(12);

    // Player 2 coin
    bus.joystick[18] = 1'b1;
    expect_at("p2coin_hi", 8, 0, 18, 32'h1);
    expect_at("p2coin_end", 9, 0, 18, 32'h0);
    expect_at("p2coin_p1", 4, 0, 8, 32'h0);
    tick(1);
    bus.joystick[18] = 1'b0;
    tick(10);

    // Autofire on bit 4; autofire_en on the coin bit has no effect
    bus.autofire_en[4] = 1'b1;
    bus.autofire_en[8] = 1'b1;
    bus.joystick[4] = 1'b1;
    bus.joystick[8] = 1'b1;
    for (int k = 1; k <= 16; k++)
      expect_at($sformatf("af%0d", k), k, 0, 4, {31'b0, ~phase_after(cyc + k - 1)});
    for (int k = 1; k <= 8; k++) expect_at($sformatf("af_coin%0d", k), k, 0, 8, 32'h1);
    expect_at("af_coin_end", 9, 0, 8, 32'h0);
    tick(1);
    bus.joystick[8] = 1'b0;
    tick(17);
    bus.joystick[4] = 1'b0;
    bus.autofire_en = '0;
    tick(2);

    // Asynchronous reset mid-operation, then priming with a stale toggle level
    bus.joystick[1] = 1'b1;
    ps2(1'b1, 1'b0, 8'h14);
    if (!tog) begin
      tick(1);
      ps2(1'b1, 1'b0, 8'h14);
    end
    expect_at("pre_rst_joy", 2, 0, 1, 32'h1);
    expect_at("pre_rst_key", 3, 0, 4, 32'h1);
    tick(3);
    #2 RESET = 1'b1;
    #1 check_val("async_rst_ctrl", 32'(bus.ctrl_out), 32'h0);
    tick(2);
    bus.joystick[1] = 1'b0;
    RESET = 1'b0; rst_cyc = cyc;
    expect_at("prime_ctrl1", 1, 1, 0, 32'h0);
    expect_at("prime_ctrl3", 3, 1, 0, 32'h0);
    expect_at("prime_svc", 3, 2, 0, 32'h0);
    tick(3);
    map_write(4, 1'b1, 1'b0, 8'h14);
    ps2(1'b1, 1'b0, 8'h14);
    expect_at("post_prime_press", 2, 0, 4, 32'h1);
    tick(4);

    check_val("sb_pending", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_mapper.md
# input_mapper

Parametrised player-input front end for arcade cores, placed between `hps_io` and the game core in the `clk_sys` domain. It decodes PS/2 key events against a runtime-loadable keymap, including extended scan codes. It merges the decoded keys with the joystick buses for any number of players, adds per-button autofire, and stretches coin pulses. It replaces a fixed per-key register list with a table-driven design.

## Interface
Parameters:
- PLAYERS, 2, number of player channels.
- JOY_W, 10, bits per player; bit order is R,L,D,U,B1,B2,B3,Start,Coin,Pause.
- SERVICE, 2, number of extra service inputs.
- COIN_BIT, 8, index within each player word treated as coin.
- COIN_HOLD, 16'd50000, minimum coin output width in clk_sys cycles.
- AF_DIV, 24'd400000, autofire half-period in clk_sys cycles.
- Derived: N = PLAYERS*JOY_W + SERVICE; AW = $clog2(N).

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  reset, asynchronous, active-high.
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] code.
- joystick  in  PLAYERS*JOY_W  player p occupies [p*JOY_W +: JOY_W], active high.
- map_wr  in  1  keymap write strobe.
- map_addr  in  AW  entry index; entries 0..N-1; player p bit b = p*JOY_W+b; service s = PLAYERS*JOY_W+s.
- map_data  in  10  {valid, ext, code[7:0]}.
- key_clear  in  1  forces all decoded key states released.
- autofire_en  in  PLAYERS*JOY_W  per-bit autofire enable.
- ctrl_out  out  PLAYERS*JOY_W  merged player controls.
- service_out  out  SERVICE  merged service inputs (keyboard only).

## Operation
- Keymap: N registers of {valid, ext, code}, all invalid after reset. A map_wr write takes effect at the clock edge. Writing entry i also clears key_state[i].
- map_addr >= N: the write is ignored.
- Event detect: old_tog register plus primed flag, both 0 at reset. On the first edge after reset, old_tog <= ps2_key[10] and primed <= 1, with no decode. After that, an event occurs on any edge where ps2_key[10] != old_tog.
- Decode: on an event, every entry i with valid && ext==ps2_key[8] && code==ps2_key[7:0] sets key_state[i] <= ps2_key[9].
  - Multiple matching entries all update.
  - An event with no match is discarded.
- Same-edge map_wr and event: the event compares against the pre-write table. The written entry's key_state ends cleared, because clear has priority.
- key_clear: key_state <= 0 on that edge, with priority over a simultaneous event.
- Raw merge: raw[i] = key_state[i] | joystick[i] for player bits. service raw = key_state.
- Autofire:
  - af_cnt counts 0..AF_DIV-1 and wraps. af_phase toggles on each wrap; reset 0, so the first phase is low.
  - For bits with autofire_en=1 and not the coin bit: out = raw & ~af_phase, so the first fire is immediate after a wrap.
  - autofire_en on a coin bit is ignored.
- Coin stretch, per player:
  - Counter cc, COIN_HOLD width, reset 0.
  - On a raw coin rising edge (previous raw sampled 0), cc <= COIN_HOLD-1. Otherwise, if cc != 0, cc decrements.
  - Coin out = raw_coin | (cc != 0).
  - A retrigger while stretching reloads cc.

## Timing
- Reset values: ctrl_out = 0, service_out = 0, key_state = 0, table invalid, af_cnt = 0, af_phase = 0, cc = 0.
- ctrl_out and service_out are registered.
- Joystick or autofire phase change to output: 1 cycle.
- PS/2 event to output: 2 edges (key_state at edge n, output at edge n+1).
- Coin output width from a 1-cycle raw pulse: exactly COIN_HOLD cycles.
- RESET asserted mid-operation clears all state asynchronously. On release, the priming rule prevents a spurious decode from a stale ps2_key[10].
- No handshakes; every input is sampled every cycle.

## Test plan
- Map key: write entry 4 = {1,0,8'h14}, then toggle ps2_key with pressed=1, code 14 → ctrl_out[4]=1 two edges later. Release event → 0.
- Extended match: entry 3 = {1,1,8'h75}. Event with ext=0, code 75 → no change. Same event with ext=1 → ctrl_out[3]=1.
- Reset priming: hold ps2_key[10]=1 through RESET release → no key_state change, all outputs 0. A subsequent toggle to 0 with a matching code decodes normally.
- Coin stretch with COIN_HOLD=8: 1-cycle joystick[8] pulse → ctrl_out[8] high exactly 8 cycles. A second pulse at cycle 5 → held until cycle 5+8.
- Autofire with AF_DIV=4: autofire_en[4]=1, joystick[4] held → ctrl_out[4] pattern 1111 0000 repeating. autofire_en[8]=1 is ignored for coin.
- Same-edge map_wr of entry 4 plus a matching press event → key_state[4]=0. key_clear with a press held → output drops next edge.
